fetch_instr_queue: RTL and testbench
====================================

Name: fetch_instr_queue

Overview:
- Consumer end of the fetch aligner interface: accepts up to four aligned 32-bit instructions per cycle and buffers them in a circular queue.
- Each input is a 128-bit line plus a contiguous low-order valid mask and the PC of lane 0.
- Presents up to two instructions per cycle, each with its PC, to decode through a valid/ready handshake.
- Sits between the fetch aligner and the decoder; decouples icache fetch timing from decode stalls.

Parameters:
- DEPTH, 16, number of instruction entries; power of two, minimum 4.
- PTR_W, 4, log2(DEPTH); pointer width.

Ports:
- clock  input  1  system clock.
- reset  input  1  reset, synchronous and active-high.
- flush  input  1  redirect; discards all queued contents.
- enq_valid  input  1  aligned line present this cycle.
- enq_instr  input  128  lane k = bits [32k+31:32k], lane 0 is the oldest instruction.
- enq_mask  input  4  lane valid mask; legal values 0000/0001/0011/0111/1111.
- enq_pc  input  64  PC of lane 0.
- enq_ready  output  1  queue can accept a full line.
- deq_valid  output  2  bit j set when decode slot j holds an instruction.
- deq_instr0, deq_instr1  output  32 each  head and head+1 instructions.
- deq_pc0, deq_pc1  output  64 each  PCs of those instructions.
- deq_ready  input  1  decode accepts every slot flagged in deq_valid.
- occupancy  output  PTR_W+1  current entry count.

Behaviour:
- Storage: DEPTH entries of {instr 32, pc 64}, plus head pointer, tail pointer (PTR_W each) and count (PTR_W+1).
- Reset and flush:
  - On reset: head = tail = count = 0. Resulting outputs: enq_ready = 1, deq_valid = 00, deq_* data = 0, occupancy = 0.
  - Storage contents are not reset; while count = 0, deq data outputs are gated to 0.
- enq_ready = (DEPTH - count) >= 4, decoded combinationally from registered count. It does not depend on deq_ready this cycle.
- Enqueue fires when enq_valid && enq_ready.
  - n_enq = number of contiguous ones in enq_mask starting at bit 0. Bits above the first zero are ignored, so a non-contiguous mask writes only its leading run.
  - Lane k (k < n_enq) is written to entry tail+k mod DEPTH with pc = enq_pc + 4k (64-bit add, wrap ignored).
  - tail advances by n_enq. Mask 0000 is a no-op even when it fires.
- Dequeue outputs are combinational from registered state:
  - deq_valid[0] = count >= 1; deq_valid[1] = count >= 2.
  - Slot 0 = entry[head], slot 1 = entry[head+1 mod DEPTH].
  - deq_valid is never 10.
- Dequeue fires when deq_ready. n_deq = popcount(deq_valid); head advances by n_deq.
- Latency: an instruction enqueued in cycle t appears at deq in cycle t+1 at the earliest. There is no same-cycle bypass.
- Simultaneous enqueue and dequeue: count_next = count + n_enq - n_deq. Dequeue reads the pre-write state, so no read/write hazard.
- Full: when count > DEPTH-4, enq_ready = 0 and enq_valid is ignored. Upstream holds its line until ready.
- Empty: deq_valid = 00 and deq_ready has no effect.
- Wrap-around: pointers wrap mod DEPTH. A single enqueue or dequeue may straddle the wrap boundary.
- Flush has priority over enqueue and dequeue in the same cycle: both are discarded, and next cycle head = tail = count = 0.
- Reset asserted mid-operation behaves identically to flush and also clears the perf counter.

Optional Feature:
- Macro: FETCH_IQ_PERF_CNT_EN.
- Defined:
  - Adds output port stall_cycles (32 bits), reset to 0 by reset only, not by flush.
  - Increments by 1 every cycle with enq_valid = 1 and enq_ready = 0. Saturates at 0xFFFFFFFF.
- Not defined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then enqueue one line: mask 1111, pc 0x80000000, lanes 0x11,0x22,0x33,0x44, deq_ready = 0 → next cycle occupancy 4, deq_valid 11, deq_instr0 0x11 @0x80000000, deq_instr1 0x22 @0x80000004.
2. Enqueue mask 0011 at pc 0x80000008, then mask 0101 → first enqueue adds 2 entries; second adds only lane 0 (occupancy +1). The PC of the last added entry equals its enq_pc.
3. Fill to 13 entries → enq_ready 0 and asserted enq_valid is ignored. Pop 2 with deq_ready → enq_ready returns to 1 the next cycle (occupancy 11).
4. Simultaneous enqueue of 4 and dequeue of 2 starting at head 14, count 2 → data wraps through entries 14,15,0,1. Next cycle occupancy 4 and ordering is preserved.
5. Occupancy 1 with deq_ready = 1 → deq_valid 01 and occupancy goes to 0. Flush asserted in the same cycle as enq_valid and deq_ready → occupancy 0 next cycle, deq_valid 00, nothing written.
6. With FETCH_IQ_PERF_CNT_EN: hold enq_valid for 5 cycles while full, then flush → stall_cycles = 5 and it stays 5 after flush. Assert reset → stall_cycles = 0.

Source files
------------

// File: rtl/fetch_instr_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_instr_queue_if
// Handshake bundle between the fetch aligner, the instruction queue and decode.
//   enq_valid  (1)   aligned line present
//   enq_instr  (128) four 32-bit lanes, lane 0 oldest
//   enq_mask   (4)   contiguous low-order lane valid mask
//   enq_pc     (64)  PC of lane 0
//   enq_ready  (1)   queue can take a full line
//   deq_valid  (2)   decode slot valid bits
//   deq_instr0/1 (32), deq_pc0/1 (64)  head and head+1 entries
//   deq_ready  (1)   decode accepts every flagged slot
// Modports: master = aligner/decode side, slave = queue.
// -----------------------------------------------------------------------------
interface fetch_instr_queue_if;
   logic         enq_valid;
   logic [127:0] enq_instr;
   logic [3:0]   enq_mask;
   logic [63:0]  enq_pc;
   logic         enq_ready;
   logic [1:0]   deq_valid;
   logic [31:0]  deq_instr0;
   logic [31:0]  deq_instr1;
   logic [63:0]  deq_pc0;
   logic [63:0]  deq_pc1;
   logic         deq_ready;

   modport master (
      output enq_valid, enq_instr, enq_mask, enq_pc, deq_ready,
      input  enq_ready, deq_valid, deq_instr0, deq_instr1, deq_pc0, deq_pc1
   );

   modport slave (
      input  enq_valid, enq_instr, enq_mask, enq_pc, deq_ready,
      output enq_ready, deq_valid, deq_instr0, deq_instr1, deq_pc0, deq_pc1
   );
endinterface

// File: rtl/fetch_instr_queue.sv
// -----------------------------------------------------------------------------
// fetch_instr_queue
// Circular instruction queue between the fetch aligner and decode. Accepts up
// to four aligned instructions per cycle, presents up to two per cycle with
// their PCs.
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   flush            redirect, discards all queued contents
//   bus              fetch_instr_queue_if.slave (enqueue + dequeue handshake)
//   occupancy        current entry count (PTR_W+1 bits)
//   stall_cycles     (FETCH_IQ_PERF_CNT_EN only) saturating count of cycles
//                    with enq_valid high while enq_ready is low
// Optional feature macro: FETCH_IQ_PERF_CNT_EN
// -----------------------------------------------------------------------------
module fetch_instr_queue #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned PTR_W = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               flush,
   fetch_instr_queue_if.slave bus,
   output logic [PTR_W:0]     occupancy
`ifdef FETCH_IQ_PERF_CNT_EN
   ,
   output logic [31:0]        stall_cycles
`endif
);

   logic [31:0]      r_instr [DEPTH];
   logic [63:0]      r_pc    [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_count;

   logic             w_clear;
   logic             w_enq_ready;
   logic             w_enq_fire;
   logic [2:0]       w_n_enq;
   logic [2:0]       w_n_enq_eff;
   logic [1:0]       w_n_deq;
   logic [1:0]       w_deq_valid;
   logic [PTR_W-1:0] w_head1;
   logic [PTR_W-1:0] w_wr_idx [4];

   assign w_clear     = reset | flush;
   // Room for a whole line is required even when fewer lanes are valid.
   assign w_enq_ready = (32'(r_count) + 32'd4) <= DEPTH;
   assign w_enq_fire  = bus.enq_valid & w_enq_ready;

   // Only the leading run of ones counts; anything above the first zero is dropped.
   always_comb begin
      w_n_enq = 3'd0;
      if (!bus.enq_mask[0])      w_n_enq = 3'd0;
      else if (!bus.enq_mask[1]) w_n_enq = 3'd1;
      else if (!bus.enq_mask[2]) w_n_enq = 3'd2;
      else if (!bus.enq_mask[3]) w_n_enq = 3'd3;
      else                       w_n_enq = 3'd4;
   end

   assign w_n_enq_eff = w_enq_fire ? w_n_enq : 3'd0;

   assign w_deq_valid = {(r_count >= (PTR_W+1)'(2)), (r_count != '0)};
   assign w_n_deq     = bus.deq_ready ? ({1'b0, w_deq_valid[0]} + {1'b0, w_deq_valid[1]}) : 2'd0;
   assign w_head1     = r_head + PTR_W'(1);

   always_comb begin
      for (int unsigned k = 0; k < 4; k++) begin
         w_wr_idx[k] = r_tail + PTR_W'(k);
      end
   end

   always_ff @(posedge clock) begin
      if (w_clear) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + PTR_W'(w_n_deq);
         r_tail  <= r_tail + PTR_W'(w_n_enq_eff);
         r_count <= r_count + (PTR_W+1)'(w_n_enq_eff) - (PTR_W+1)'(w_n_deq);
      end
   end

   // Storage is never reset; the output gating hides stale contents.
   always_ff @(posedge clock) begin
      for (int unsigned k = 0; k < 4; k++) begin
         if (!w_clear && (k < 32'(w_n_enq_eff))) begin
            r_instr[w_wr_idx[k]] <= bus.enq_instr[32*k +: 32];
            r_pc[w_wr_idx[k]]    <= bus.enq_pc + 64'(4*k);
         end
      end
   end

   assign bus.enq_ready  = w_enq_ready;
   assign bus.deq_valid  = w_deq_valid;
   assign bus.deq_instr0 = w_deq_valid[0] ? r_instr[r_head]  : '0;
   assign bus.deq_pc0    = w_deq_valid[0] ? r_pc[r_head]     : '0;
   assign bus.deq_instr1 = w_deq_valid[1] ? r_instr[w_head1] : '0;
   assign bus.deq_pc1    = w_deq_valid[1] ? r_pc[w_head1]    : '0;
   assign occupancy      = r_count;

`ifdef FETCH_IQ_PERF_CNT_EN
   logic [31:0] r_stall_cycles;

   // Cleared by reset only; a flush keeps the history.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_stall_cycles <= '0;
      end else if (bus.enq_valid && !w_enq_ready && (r_stall_cycles != '1)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fetch_instr_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_instr_queue
// Self-checking bench for fetch_instr_queue: directed scenarios plus a
// randomized run checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_fetch_instr_queue;
   logic        clock = 1'b0;
   logic        reset;
   logic        flush;
   logic [4:0]  occupancy;
`ifdef FETCH_IQ_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [31:0] m_stall = 32'd0;
`endif

   fetch_instr_queue_if bus ();

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic [95:0] mq [$];   // {pc, instr}, front = oldest

   always #5 clock = ~clock;

   fetch_instr_queue #(.DEPTH(16), .PTR_W(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .flush        (flush),
      .bus          (bus),
      .occupancy    (occupancy)
`ifdef FETCH_IQ_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1, "timeout");
   end

   function automatic int unsigned lead_ones(input logic [3:0] m);
      int unsigned n = 0;
      while (n < 4 && m[n]) n++;
      return n;
   endfunction

   task automatic drive(input logic v, input logic [3:0] m, input logic [63:0] pc,
                        input logic [127:0] ins, input logic dr, input logic fl);
      bus.enq_valid = v;
      bus.enq_mask  = m;
      bus.enq_pc    = pc;
      bus.enq_instr = ins;
      bus.deq_ready = dr;
      flush         = fl;
   endtask

   // Advance the reference model with the inputs currently applied, then clock.
   task automatic tick();
      int unsigned sz = mq.size();
      bit          rdy = (sz + 4) <= 16;
      int unsigned nd, ne;
`ifdef FETCH_IQ_PERF_CNT_EN
      if (reset) m_stall = 32'd0;
      else if (bus.enq_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
      if (reset || flush) begin
         mq.delete();
      end else begin
         nd = bus.deq_ready ? ((sz >= 2) ? 2 : sz) : 0;
         ne = (bus.enq_valid && rdy) ? lead_ones(bus.enq_mask) : 0;
         for (int unsigned j = 0; j < nd; j++) void'(mq.pop_front());
         for (int unsigned k = 0; k < ne; k++)
            mq.push_back({bus.enq_pc + 64'(4*k), bus.enq_instr[32*k +: 32]});
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 4'h0, 64'h0, 128'h0, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      n_tests++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
      n_tests++; if (bus.enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ready: got %b want 1", bus.enq_ready); end
      n_tests++; if (bus.deq_valid !== 2'b00) begin n_fail++; $display("FAIL reset_deq_valid: got %b want 00", bus.deq_valid); end
      n_tests++; if (bus.deq_instr0 !== 32'h0 || bus.deq_pc0 !== 64'h0) begin n_fail++; $display("FAIL reset_deq_data: got %h @%h want 0 @0", bus.deq_instr0, bus.deq_pc0); end
`ifdef FETCH_IQ_PERF_CNT_EN
      n_tests++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
`endif
   endtask

   task automatic test_enqueue_basic();
      drive(1'b1, 4'b1111, 64'h8000_0000, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0, 1'b0);
      n_tests++; if (bus.deq_valid !== 2'b00) begin n_fail++; $display("FAIL no_bypass: got %b want 00", bus.deq_valid); end
      tick();
      drive(1'b0, 4'h0, 64'h0, 128'h0, 1'b0, 1'b0);
      n_tests++; if (occupancy !== 5'd4) begin n_fail++; $display("FAIL basic_occ: got %0d want 4", occupancy); end
      n_tests++; if (bus.deq_valid !== 2'b11) begin n_fail++; $display("FAIL basic_deq_valid: got %b want 11", bus.deq_valid); end
      n_tests++; if (bus.deq_instr0 !== 32'h11 || bus.deq_pc0 !== 64'h8000_0000) begin n_fail++; $display("FAIL basic_slot0: got %h @%h want 11 @80000000", bus.deq_instr0, bus.deq_pc0); end
      n_tests++; if (bus.deq_instr1 !== 32'h22 || bus.deq_pc1 !== 64'h8000_0004) begin n_fail++; $display("FAIL basic_slot1: got %h @%h want 22 @80000004", bus.deq_instr1, bus.deq_pc1); end
   endtask

   task automatic test_partial_mask();
      drive(1'b1, 4'b0011, 64'h8000_0008, {32'hEE, 32'hDD, 32'h66, 32'h55}, 1'b0, 1'b0);
      tick();
      n_tests++; if (occupancy !== 5'd6) begin n_fail++; $display("FAIL mask0011_occ: got %0d want 6", occupancy); end
      drive(1'b1, 4'b0101, 64'h8000_0010, {32'hCC, 32'h99, 32'hBB, 32'h77}, 1'b0, 1'b0);
      tick();
      n_tests++; if (occupancy !== 5'd7) begin n_fail++; $display("FAIL mask0101_occ: got %0d want 7", occupancy); end
      drive(1'b0, 4'h0, 64'h0, 128'h0, 1'b1, 1'b0);
      tick();
      tick();
      n_tests++; if (bus.deq_instr0 !== 32'h55 || bus.deq_pc0 !== 64'h8000_0008) begin n_fail++; $display("FAIL mask_slot0: got %h @%h want 55 @80000008", bus.deq_instr0, bus.deq_pc0); end
      n_tests++; if (bus.deq_instr1 !== 32'h66 || bus.deq_pc1 !== 64'h8000_000C) begin n_fail++; $display("FAIL mask_slot1: got %h @%h want 66 @8000000c", bus.deq_instr1, bus.deq_pc1); end
      tick();
      n_tests++; if (occupancy !== 5'd1 || bus.deq_valid !== 2'b01) begin n_fail++; $display("FAIL one_left: got occ %0d dv %b want 1 01", occupancy, bus.deq_valid); end
      n_tests++; if (bus.deq_instr0 !== 32'h77 || bus.deq_pc0 !== 64'h8000_0010) begin n_fail++; $display("FAIL last_lane_pc: got %h @%h want 77 @80000010", bus.deq_instr0, bus.deq_pc0); end
      n_tests++; if (bus.deq_instr1 !== 32'h0) begin n_fail++; $display("FAIL slot1_gated: got %h want 0", bus.deq_instr1); end
      tick();
      n_tests++; if (occupancy !== 5'd0 || bus.deq_valid !== 2'b00 || bus.deq_instr0 !== 32'h0) begin n_fail++; $display("FAIL drained: got occ %0d dv %b i0 %h want 0 00 0", occupancy, bus.deq_valid, bus.deq_instr0); end
   endtask

   task automatic test_full();
      logic [127:0] ins;
      for (int unsigned i = 0; i < 4; i++) begin
         for (int unsigned k = 0; k < 4; k++) ins[32*k +: 32] = 32'h1000 + 32'(4*i + k);
         drive(1'b1, (i == 3) ? 4'b0001 : 4'b1111, 64'h4000 + 64'(16*i), ins, 1'b0, 1'b0);
         tick();
      end
      n_tests++; if (occupancy !== 5'd13 || bus.enq_ready !== 1'b0) begin n_fail++; $display("FAIL full_state: got occ %0d rdy %b want 13 0", occupancy, bus.enq_ready); end
      drive(1'b1, 4'b1111, 64'h7000, 128'hFFFF, 1'b0, 1'b0);
      tick();
      n_tests++; if (occupancy !== 5'd13) begin n_fail++; $display("FAIL full_ignore: got %0d want 13", occupancy); end
      n_tests++; if (bus.deq_instr0 !== 32'h1000) begin n_fail++; $display("FAIL full_head: got %h want 1000", bus.deq_instr0); end
      drive(1'b1, 4'b1111, 64'h7000, 128'hFFFF, 1'b1, 1'b0);
      tick();
      n_tests++; if (occupancy !== 5'd11 || bus.enq_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop: got occ %0d rdy %b want 11 1", occupancy, bus.enq_ready); end
      n_tests++; if (bus.deq_instr0 !== 32'h1002 || bus.deq_pc0 !== 64'h4008) begin n_fail++; $display("FAIL full_pop_head: got %h @%h want 1002 @4008", bus.deq_instr0, bus.deq_pc0); end
      drive(1'b0, 4'h0, 64'h0, 128'h0, 1'b0, 1'b1);
      tick();
      flush = 1'b0;
      n_tests++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL full_flush: got %0d want 0", occupancy); end
   endtask

   task automatic test_wrap();
      for (int unsigned i = 0; i < 3; i++) begin
         drive(1'b1, 4'b1111, 64'h3000 + 64'(16*i), {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 4'h0, 64'h0, 128'h0, 1'b1, 1'b0);
      repeat (6) tick();
      drive(1'b1, 4'b0011, 64'h5000, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
      tick();
      drive(1'b0, 4'h0, 64'h0, 128'h0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 4'b0011, 64'h1000, {32'h0, 32'h0, 32'hA1, 32'hA0}, 1'b0, 1'b0);
      tick();
      n_tests++; if (occupancy !== 5'd2 || bus.deq_instr0 !== 32'hA0 || bus.deq_instr1 !== 32'hA1) begin n_fail++; $display("FAIL wrap_pre: got occ %0d %h %h want 2 a0 a1", occupancy, bus.deq_instr0, bus.deq_instr1); end
      drive(1'b1, 4'b1111, 64'h2000, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b1, 1'b0);
      tick();
      n_tests++; if (occupancy !== 5'd4) begin n_fail++; $display("FAIL wrap_occ: got %0d want 4", occupancy); end
      n_tests++; if (bus.deq_instr0 !== 32'hB0 || bus.deq_pc0 !== 64'h2000 || bus.deq_instr1 !== 32'hB1 || bus.deq_pc1 !== 64'h2004) begin n_fail++; $display("FAIL wrap_order0: got %h @%h %h @%h want b0 @2000 b1 @2004", bus.deq_instr0, bus.deq_pc0, bus.deq_instr1, bus.deq_pc1); end
      drive(1'b0, 4'h0, 64'h0, 128'h0, 1'b1, 1'b0);
      tick();
      n_tests++; if (bus.deq_instr0 !== 32'hB2 || bus.deq_pc0 !== 64'h2008 || bus.deq_instr1 !== 32'hB3 || bus.deq_pc1 !== 64'h200C) begin n_fail++; $display("FAIL wrap_order1: got %h @%h %h @%h want b2 @2008 b3 @200c", bus.deq_instr0, bus.deq_pc0, bus.deq_instr1, bus.deq_pc1); end
   endtask

   task automatic test_flush();
      drive(1'b1, 4'b1111, 64'h9000, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);
      tick();
      drive(1'b0, 4'h0, 64'h0, 128'h0, 1'b0, 1'b0);
      n_tests++; if (occupancy !== 5'd0 || bus.deq_valid !== 2'b00 || bus.enq_ready !== 1'b1) begin n_fail++; $display("FAIL flush_state: got occ %0d dv %b rdy %b want 0 00 1", occupancy, bus.deq_valid, bus.enq_ready); end
      tick();
      n_tests++; if (occupancy !== 5'd0 || bus.deq_instr0 !== 32'h0) begin n_fail++; $display("FAIL flush_nowrite: got occ %0d i0 %h want 0 0", occupancy, bus.deq_instr0); end
   endtask

`ifdef FETCH_IQ_PERF_CNT_EN
   task automatic test_perf();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_tests++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL perf_reset0: got %0d want 0", stall_cycles); end
      for (int unsigned i = 0; i < 4; i++) begin
         drive(1'b1, (i == 3) ? 4'b0001 : 4'b1111, 64'h100 * 64'(i), {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 4'b1111, 64'h0, 128'h0, 1'b0, 1'b0);
      repeat (5) tick();
      n_tests++; if (stall_cycles !== 32'd5) begin n_fail++; $display("FAIL perf_count: got %0d want 5", stall_cycles); end
      drive(1'b0, 4'h0, 64'h0, 128'h0, 1'b0, 1'b1);
      tick();
      flush = 1'b0;
      n_tests++; if (stall_cycles !== 32'd5 || occupancy !== 5'd0) begin n_fail++; $display("FAIL perf_flush: got stall %0d occ %0d want 5 0", stall_cycles, occupancy); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_tests++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL perf_reset: got %0d want 0", stall_cycles); end
   endtask
`endif

   task automatic test_random();
      logic [3:0]   legal [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
      logic [3:0]   m;
      logic [95:0]  e0, e1;
      logic [1:0]   e_dv;
      int unsigned  sz, r;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
         r = $urandom_range(0, 7);
         m = (r < 5) ? legal[r] : 4'($urandom);
         drive($urandom_range(0, 9) < 7, m, {$urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom},
               $urandom_range(0, 9) < ((cyc / 500) % 2 == 0 ? 5 : 8),
               $urandom_range(0, 59) == 0);
         reset = ($urandom_range(0, 299) == 0);
         sz   = mq.size();
         e0   = (sz >= 1) ? mq[0] : 96'h0;
         e1   = (sz >= 2) ? mq[1] : 96'h0;
         e_dv = (sz >= 2) ? 2'b11 : ((sz == 1) ? 2'b01 : 2'b00);
         n_tests++; if (occupancy !== 5'(sz)) begin n_fail++; $display("FAIL rnd_occ c%0d: got %0d want %0d", cyc, occupancy, sz); end
         n_tests++; if (bus.enq_ready !== ((sz + 4) <= 16)) begin n_fail++; $display("FAIL rnd_rdy c%0d: got %b want %b", cyc, bus.enq_ready, (sz + 4) <= 16); end
         n_tests++; if (bus.deq_valid !== e_dv) begin n_fail++; $display("FAIL rnd_dv c%0d: got %b want %b", cyc, bus.deq_valid, e_dv); end
         n_tests++; if ({bus.deq_pc0, bus.deq_instr0} !== e0) begin n_fail++; $display("FAIL rnd_slot0 c%0d: got %h @%h want %h", cyc, bus.deq_instr0, bus.deq_pc0, e0); end
         n_tests++; if ({bus.deq_pc1, bus.deq_instr1} !== e1) begin n_fail++; $display("FAIL rnd_slot1 c%0d: got %h @%h want %h", cyc, bus.deq_instr1, bus.deq_pc1, e1); end
`ifdef FETCH_IQ_PERF_CNT_EN
         n_tests++; if (stall_cycles !== m_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %0d want %0d", cyc, stall_cycles, m_stall); end
`endif
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_enqueue_basic();
      test_partial_mask();
      test_full();
      test_wrap();
      test_flush();
`ifdef FETCH_IQ_PERF_CNT_EN
      test_perf();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
